// File: rtl/mfm_data_separator.sv
// Digital-PLL data separator for MFM read data: recovers the cell clock,
// slices pulses into clock/data cells, decodes data bits and tracks lock.
module mfm_data_separator #(
    parameter int CELL_CLKS   = 10,
    parameter int PHASE_SHIFT = 1,
    parameter int MAX_CORR    = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_COUNT  = 16,
    parameter int MAX_GAP     = 4
) (
    input  logic clk_50,
    input  logic reset,
    input  logic enable,
    input  logic raw_mfm,
    output logic clk_cell,
    output logic cell_valid,
    output logic cell_bit,
    output logic bit_valid,
    output logic bit_data,
    output logic locked,
    output logic pulse_err
);

    localparam int PW = $clog2(CELL_CLKS);
    localparam int SW = PW + 2;
    localparam int GW = $clog2(MAX_GAP + 2);
    localparam logic signed [SW-1:0] CC   = SW'(CELL_CLKS);
    localparam logic signed [SW-1:0] CTR  = SW'(CELL_CLKS / 2);
    localparam logic signed [SW-1:0] MAXC = SW'(MAX_CORR);
    localparam logic signed [SW-1:0] TOL  = SW'(LOCK_TOL);
    localparam logic signed [SW-1:0] ONE  = SW'(1);

    logic [2:0]    sync;
    logic [PW-1:0] ph;
    logic          pseen;
    logic          parity;
    logic          prev_bit;
    logic [7:0]    lock_cnt;
    logic [GW-1:0] gap;

    logic                 p;
    logic signed [SW-1:0] err;
    logic signed [SW-1:0] mag;
    logic signed [SW-1:0] corr;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    logic                 wrap;
    logic [PW-1:0]        ph_next;
    logic                 cb;
    logic                 err_cell;
    logic                 in_tol;
    logic [GW-1:0]        gap_inc;
    logic                 gap_over;
    logic                 clear_lock;

    always_comb begin
        p    = sync[1] & ~sync[2];
        err  = $signed(SW'(ph)) - CTR;
        mag  = err[SW-1] ? -err : err;
        corr = mag >>> PHASE_SHIFT;
        if (corr > MAXC)
            corr = MAXC;
        step = ONE;
        if (p && err > 0)
            step = ONE - corr;
        else if (p && err < 0)
            step = ONE + corr;
        sum     = $signed(SW'(ph)) + step;
        wrap    = (sum >= CC);
        ph_next = wrap ? PW'(sum - CC) : PW'(sum);

        // A pulse in the wrap cycle still belongs to the ending cell.
        cb         = pseen | p;
        err_cell   = wrap & prev_bit & cb;
        in_tol     = (mag <= TOL);
        gap_inc    = (gap == '1) ? gap : gap + 1'b1;
        gap_over   = wrap & ~cb & (gap_inc > GW'(MAX_GAP));
        clear_lock = (p & ~in_tol) | gap_over | err_cell;
    end

    always_ff @(posedge clk_50) begin
        if (reset || !enable) begin
            sync       <= '0;
            ph         <= '0;
            pseen      <= 1'b0;
            parity     <= 1'b0;
            prev_bit   <= 1'b0;
            lock_cnt   <= '0;
            gap        <= '0;
            clk_cell   <= 1'b0;
            cell_valid <= 1'b0;
            cell_bit   <= 1'b0;
            bit_valid  <= 1'b0;
            bit_data   <= 1'b0;
            locked     <= 1'b0;
            pulse_err  <= 1'b0;
        end else begin
            sync <= {sync[1:0], raw_mfm};
            ph   <= ph_next;
            // Registered decode of the next phase keeps clk_cell glitch-free.
            clk_cell   <= (ph_next < PW'(CELL_CLKS / 2));
            cell_valid <= wrap;
            cell_bit   <= wrap & cb;
            bit_valid  <= wrap & ~err_cell & parity;
            bit_data   <= wrap & ~err_cell & parity & cb;
            pulse_err  <= err_cell;

            if (wrap) begin
                prev_bit <= cb;
                pseen    <= 1'b0;
                // Holding parity on a violation slips the clock/data pairing.
                if (!err_cell)
                    parity <= ~parity;
            end else if (p) begin
                pseen <= 1'b1;
            end

            if (p)
                gap <= '0;
            else if (wrap && !pseen)
                gap <= gap_inc;

            if (clear_lock) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                if (p && lock_cnt != 8'hFF)
                    lock_cnt <= lock_cnt + 8'd1;
                locked <= (lock_cnt >= 8'(LOCK_COUNT));
            end
        end
    end

endmodule

// File: tb/tb_mfm_data_separator.sv
// Scoreboard bench for mfm_data_separator: per-cell expectations are queued
// from hand-derived pulse schedules and checked at every cell_valid strobe.
module tb_mfm_data_separator;

    logic clk_50  = 1'b0;
    logic reset   = 1'b1;
    logic enable  = 1'b1;
    logic raw_mfm = 1'b0;
    logic clk_cell, cell_valid, cell_bit, bit_valid, bit_data, locked, pulse_err;

    mfm_data_separator dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .enable     (enable),
        .raw_mfm    (raw_mfm),
        .clk_cell   (clk_cell),
        .cell_valid (cell_valid),
        .cell_bit   (cell_bit),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .locked     (locked),
        .pulse_err  (pulse_err)
    );

    always #5 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    typedef struct {
        int t;
        bit cb;
        bit bv;
        bit bd;
        bit pe;
        bit lk;
    } exp_t;

    exp_t sb[$];
    int   t0     = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic push(input int t, input bit cb, input bit bv,
                        input bit pe, input bit lk);
        exp_t e;
        e.t  = t;
        e.cb = cb;
        e.bv = bv;
        e.bd = bv & cb;
        e.pe = pe;
        e.lk = lk;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_50);
            if (cell_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL cell_unexpected at t=%0d", cyc - t0);
                end else begin
                    e = sb.pop_front();
                    if (cyc - t0 != e.t ||
                        {cell_bit, bit_valid, bit_data, pulse_err, locked} !==
                        {e.cb, e.bv, e.bd, e.pe, e.lk}) begin
                        n_fail++;
                        $display("FAIL cell t=%0d bit/bv/bd/pe/lk=%b%b%b%b%b, required t=%0d %b%b%b%b%b",
                                 cyc - t0, cell_bit, bit_valid, bit_data, pulse_err, locked,
                                 e.t, e.cb, e.bv, e.bd, e.pe, e.lk);
                    end
                end
                n_chk++;
                if (clk_cell !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clk_cell_at_wrap: got %b, required 1", clk_cell);
                end
            end else if (bit_valid || pulse_err) begin
                n_chk++;
                n_fail++;
                $display("FAIL strobe_outside_cell: bv=%b pe=%b, required 0", bit_valid, pulse_err);
            end
        end
    endtask

    task automatic wait_rel(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    // Raw pulse timed so the synchronised strobe p is high in cycle k.
    task automatic pulse(input int k);
        wait_rel(k - 2);
        raw_mfm = 1'b1;
        wait_rel(k);
        raw_mfm = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk_50);
        #1;
        reset = 1'b0;
        t0    = cyc;
    endtask

    function automatic logic [7:0] outs();
        return {1'b0, clk_cell, cell_valid, cell_bit, bit_valid, bit_data, locked, pulse_err};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit cb;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk_50);
        #1;
        chk("reset_state", outs(), 8'h00);
        release_reset();

        // Run 1: ideal lock, pattern decode, gap loss, relock, phase-error drop.
        for (int n = 1; n <= 87; n++) begin
            cb = ((n % 2 == 1) && (n <= 33 || (n >= 53 && n <= 87))) ||
                 (n == 35) || (n == 38) || (n == 40) || (n == 44) || (n == 47);
            push((n == 87) ? 871 : 10 * n, cb, (n % 2 == 0), 1'b0,
                 ((n >= 31 && n <= 51) || (n >= 83 && n <= 86)));
        end
        wait_rel(3);
        chk("clk_cell_low_half", {7'd0, clk_cell}, 8'd1);
        for (int j = 0; j <= 16; j++) begin
            pulse(5 + 20 * j);
            if (j == 0)
                chk("clk_cell_high_half", {7'd0, clk_cell}, 8'd0);
        end
        pulse(345);
        pulse(375);
        pulse(395);
        pulse(435);
        pulse(465);
        for (int j = 0; j <= 16; j++)
            pulse(525 + 20 * j);
        pulse(868);

        // Reset raised mid-cell with a pulse in flight.
        wait_rel(874);
        raw_mfm = 1'b1;
        wait_rel(875);
        chk("pre_reset_clk_cell", {7'd0, clk_cell}, 8'd1);
        reset = 1'b1;
        wait_rel(876);
        chk("reset_midcell", outs(), 8'h00);
        raw_mfm = 1'b0;
        chk("run1_queue_drained", 8'(sb.size()), 8'd0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_50);
            #1;
            chk("reset_idle", outs(), 8'h00);
        end

        // Run 2: pull-in from ph=8, lock, MFM violation and realigned decode.
        release_reset();
        for (int n = 1; n <= 53; n++) begin
            cb = ((n % 2 == 1) && n <= 39) || (n == 40) || (n == 43) ||
                 (n == 46) || (n == 49) || (n == 51);
            push((n == 1) ? 11 : (n == 2) ? 21 : 10 * n + 2, cb,
                 (n <= 39) ? (n % 2 == 0) : (n == 40) ? 1'b0 : (n % 2 == 1),
                 (n == 40), (n >= 35 && n <= 39));
        end
        for (int j = 0; j <= 18; j++)
            pulse(8 + 20 * j);
        pulse(388);
        pulse(398);
        pulse(428);
        pulse(458);
        pulse(488);
        pulse(508);

        wait_rel(535);
        chk("pre_disable_clk_cell", {7'd0, clk_cell}, 8'd1);
        enable = 1'b0;
        wait_rel(536);
        chk("enable_low", outs(), 8'h00);
        chk("run2_queue_drained", 8'(sb.size()), 8'd0);
        repeat (20) @(posedge clk_50);
        #1;
        chk("enable_low_idle", outs(), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
